tank_motion_ctrl: RTL and testbench
===================================

Name: tank_motion_ctrl

Overview:
Downstream consumer of the 5-bit tank command bus (bit0 DOWN, bit1 RIGHT, bit2 UP, bit3 LEFT, bit4 FIRE), as produced by the autonomous tank drivers and the player input decoder.
Converts commands into tile-grid position and heading, paced by a frame tick. Checks each step against the map through a req/ack lookup port. Issues bullet launch requests over a valid/ready handshake with a cooldown between shots.

Parameters:
GRID_W, 26, map width in tiles; legal x is 0..GRID_W-1
GRID_H, 26, map height in tiles; legal y is 0..GRID_H-1
START_X, 8, x position after reset
START_Y, 24, y position after reset
START_DIR, 2, heading after reset (0 down, 1 right, 2 up, 3 left)
STEP_DIV, 4, number of ticks per one-tile step
FIRE_COOLDOWN, 32, ticks after an accepted shot before the next shot may be requested

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
tick  in  1  one-cycle frame-rate pulse
cmd  in  5  command bus; sampled only on tick cycles
map_req  out  1  map lookup request
map_x  out  5  lookup tile x; held stable while map_req=1
map_y  out  5  lookup tile y; held stable while map_req=1
map_ack  in  1  lookup done; map_blocked is valid in the same cycle
map_blocked  in  1  1 = target tile is wall/water/tank
pos_x  out  5  current tile x
pos_y  out  5  current tile y
dir  out  2  current heading
moving  out  1  one-cycle pulse in the cycle pos changes
fire_valid  out  1  bullet launch request
fire_ready  in  1  bullet engine accepts the request
fire_x  out  5  launch tile x snapshot
fire_y  out  5  launch tile y snapshot
fire_dir  out  2  launch heading snapshot

Behaviour:
- Reset (synchronous, active-high; clock clk) values: pos=START_X/START_Y, dir=START_DIR, map_req=0, moving=0, fire_valid=0, cooldown=0, step_cnt=0, FSM=IDLE. Reset asserted mid-lookup or mid-handshake drops map_req/fire_valid on the next edge. An ack arriving after reset is ignored.
- Direction decode of cmd[3:0]:
  - Exactly one bit set: that direction is requested.
  - Zero bits, or two or more bits set: no motion request. step_cnt clears; dir is unchanged.
- Motion FSM states: IDLE, QUERY, COMMIT.
- IDLE, on a tick with a valid request:
  - Requested dir != dir: dir <= requested on the next edge; step_cnt=0; no move (a turn costs one tick).
  - Requested dir == dir, step_cnt < STEP_DIV-1: step_cnt increments.
  - Requested dir == dir, step_cnt == STEP_DIV-1: step_cnt=0, then compute the target tile (down y+1, right x+1, up y-1, left x-1).
  - Target outside 0..GRID-1 (edge wrap is forbidden): no lookup; stay in IDLE.
  - Target inside the grid: map_req=1 with map_x/map_y=target on the next cycle; go to QUERY.
- QUERY: hold map_req, map_x and map_y until map_ack.
  - On ack with map_blocked=0: go to COMMIT.
  - On ack with map_blocked=1: go to IDLE; pos unchanged.
  - map_req drops in the cycle after ack.
  - Ticks arriving during QUERY/COMMIT are ignored for motion, but still decrement cooldown.
- COMMIT: pos <= target and moving=1 for exactly one cycle, then IDLE.
- Minimum latency from the triggering tick to the pos update is tick + 1 (req) + ack cycle + 1.
- Fire path runs independently of the motion FSM:
  - cooldown decrements by 1 on each tick while nonzero; it saturates at 0.
  - On a tick with cmd[4]=1, cooldown=0 and fire_valid=0: on the next edge, fire_valid=1 and fire_x/y/dir = pos/dir as of the tick cycle (pre-move, post-reset values).
  - fire_valid and the snapshot are held until fire_valid & fire_ready. On that edge: fire_valid=0, cooldown=FIRE_COOLDOWN.
  - FIRE requests while fire_valid=1 or cooldown>0 are discarded, not queued.
- A simultaneous turn and fire in the same tick uses the pre-turn dir for the snapshot.

Test Plan:
- Reset, then cmd=5'b00100 for 4 ticks with map_ack next cycle, map_blocked=0 -> dir=2, then pos_y 24->23 after the 4th tick, moving pulses once.
- From dir=2, cmd=5'b01000 one tick -> dir=3 the next cycle, pos unchanged, no map_req; 4 more ticks -> pos_x 8->7.
- pos_x=0, dir=3, LEFT for 4 ticks -> map_req never asserts, pos_x stays 0, moving stays 0.
- Blocked lookup: map_ack delayed 3 cycles with map_blocked=1 -> map_x/map_y stable for all 3 cycles, pos unchanged, FSM back in IDLE.
- cmd=5'b10000 on a tick with fire_ready held low 5 cycles -> fire_valid=1 with fire_x=8, fire_y=24, fire_dir=2 stable until accepted; the next FIRE is ignored until 32 ticks have elapsed.
- cmd=5'b00011 (illegal two-hot) on a tick -> no turn, no move; reset asserted during QUERY -> map_req=0 and pos=(8,24) on the next cycle.

Source files
------------

// File: rtl/tank_motion_ctrl.sv
// Tank motion and fire controller: turns 5-bit tank commands into tile-grid steps,
// validated against the map over a req/ack port, plus a cooldown-paced bullet launcher.
module tank_motion_ctrl #(
    parameter int GRID_W        = 26,
    parameter int GRID_H        = 26,
    parameter int START_X       = 8,
    parameter int START_Y       = 24,
    parameter int START_DIR     = 2,
    parameter int STEP_DIV      = 4,
    parameter int FIRE_COOLDOWN = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [4:0] cmd,
    output logic       map_req,
    output logic [4:0] map_x,
    output logic [4:0] map_y,
    input  logic       map_ack,
    input  logic       map_blocked,
    output logic [4:0] pos_x,
    output logic [4:0] pos_y,
    output logic [1:0] dir,
    output logic       moving,
    output logic       fire_valid,
    input  logic       fire_ready,
    output logic [4:0] fire_x,
    output logic [4:0] fire_y,
    output logic [1:0] fire_dir
);

    localparam logic [4:0] MAX_X       = 5'(GRID_W - 1);
    localparam logic [4:0] MAX_Y       = 5'(GRID_H - 1);
    localparam logic [4:0] START_X_V   = 5'(START_X);
    localparam logic [4:0] START_Y_V   = 5'(START_Y);
    localparam logic [1:0] START_DIR_V = 2'(START_DIR);
    localparam logic [7:0] STEP_LAST   = 8'(STEP_DIV - 1);
    localparam int         CD_W        = (FIRE_COOLDOWN < 1) ? 1 : $clog2(FIRE_COOLDOWN + 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(FIRE_COOLDOWN);

    localparam logic [1:0] DIR_DOWN  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        QUERY  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      pos_x_q, pos_x_d;
    logic [4:0]      pos_y_q, pos_y_d;
    logic [1:0]      dir_q, dir_d;
    logic [7:0]      step_cnt_q, step_cnt_d;
    logic [4:0]      tgt_x_q, tgt_x_d;
    logic [4:0]      tgt_y_q, tgt_y_d;
    logic            map_req_q, map_req_d;
    logic            moving_q, moving_d;
    logic [CD_W-1:0] cooldown_q, cooldown_d;
    logic            fire_valid_q, fire_valid_d;
    logic [4:0]      fire_x_q, fire_x_d;
    logic [4:0]      fire_y_q, fire_y_d;
    logic [1:0]      fire_dir_q, fire_dir_d;

    logic            req_valid;
    logic [1:0]      req_dir;
    logic [4:0]      next_x;
    logic [4:0]      next_y;
    logic            in_grid;

    // Only a single asserted direction bit counts as a motion request.
    always_comb begin
        req_valid = 1'b1;
        req_dir   = DIR_DOWN;
        case (cmd[3:0])
            4'b0001: req_dir = DIR_DOWN;
            4'b0010: req_dir = DIR_RIGHT;
            4'b0100: req_dir = DIR_UP;
            4'b1000: req_dir = DIR_LEFT;
            default: req_valid = 1'b0;
        endcase
    end

    // Edge tests compare against the current position so the target never wraps.
    always_comb begin
        next_x  = pos_x_q;
        next_y  = pos_y_q;
        in_grid = 1'b1;
        case (dir_q)
            DIR_DOWN: begin
                next_y  = pos_y_q + 5'd1;
                in_grid = (pos_y_q < MAX_Y);
            end
            DIR_RIGHT: begin
                next_x  = pos_x_q + 5'd1;
                in_grid = (pos_x_q < MAX_X);
            end
            DIR_UP: begin
                next_y  = pos_y_q - 5'd1;
                in_grid = (pos_y_q != 5'd0);
            end
            default: begin
                next_x  = pos_x_q - 5'd1;
                in_grid = (pos_x_q != 5'd0);
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        dir_d        = dir_q;
        step_cnt_d   = step_cnt_q;
        tgt_x_d      = tgt_x_q;
        tgt_y_d      = tgt_y_q;
        map_req_d    = map_req_q;
        moving_d     = 1'b0;
        cooldown_d   = cooldown_q;
        fire_valid_d = fire_valid_q;
        fire_x_d     = fire_x_q;
        fire_y_d     = fire_y_q;
        fire_dir_d   = fire_dir_q;

        case (state_q)
            IDLE: begin
                if (tick) begin
                    if (!req_valid) begin
                        step_cnt_d = 8'd0;
                    end else if (req_dir != dir_q) begin
                        dir_d      = req_dir;
                        step_cnt_d = 8'd0;
                    end else if (step_cnt_q != STEP_LAST) begin
                        step_cnt_d = step_cnt_q + 8'd1;
                    end else begin
                        step_cnt_d = 8'd0;
                        if (in_grid) begin
                            tgt_x_d   = next_x;
                            tgt_y_d   = next_y;
                            map_req_d = 1'b1;
                            state_d   = QUERY;
                        end
                    end
                end
            end
            QUERY: begin
                if (map_ack) begin
                    map_req_d = 1'b0;
                    state_d   = map_blocked ? IDLE : COMMIT;
                end
            end
            COMMIT: begin
                pos_x_d  = tgt_x_q;
                pos_y_d  = tgt_y_q;
                moving_d = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                map_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        // Acceptance wins over a same-cycle tick so the full cooldown is always served.
        if (fire_valid_q && fire_ready) begin
            fire_valid_d = 1'b0;
            cooldown_d   = CD_LOAD;
        end else if (tick) begin
            if (cooldown_q != '0) begin
                cooldown_d = cooldown_q - 1'b1;
            end else if (cmd[4] && !fire_valid_q) begin
                fire_valid_d = 1'b1;
                fire_x_d     = pos_x_q;
                fire_y_d     = pos_y_q;
                fire_dir_d   = dir_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pos_x_q      <= START_X_V;
            pos_y_q      <= START_Y_V;
            dir_q        <= START_DIR_V;
            step_cnt_q   <= 8'd0;
            tgt_x_q      <= START_X_V;
            tgt_y_q      <= START_Y_V;
            map_req_q    <= 1'b0;
            moving_q     <= 1'b0;
            cooldown_q   <= '0;
            fire_valid_q <= 1'b0;
            fire_x_q     <= START_X_V;
            fire_y_q     <= START_Y_V;
            fire_dir_q   <= START_DIR_V;
        end else begin
            state_q      <= state_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            dir_q        <= dir_d;
            step_cnt_q   <= step_cnt_d;
            tgt_x_q      <= tgt_x_d;
            tgt_y_q      <= tgt_y_d;
            map_req_q    <= map_req_d;
            moving_q     <= moving_d;
            cooldown_q   <= cooldown_d;
            fire_valid_q <= fire_valid_d;
            fire_x_q     <= fire_x_d;
            fire_y_q     <= fire_y_d;
            fire_dir_q   <= fire_dir_d;
        end
    end

    assign map_req    = map_req_q;
    assign map_x      = tgt_x_q;
    assign map_y      = tgt_y_q;
    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign dir        = dir_q;
    assign moving     = moving_q;
    assign fire_valid = fire_valid_q;
    assign fire_x     = fire_x_q;
    assign fire_y     = fire_y_q;
    assign fire_dir   = fire_dir_q;

endmodule

// File: tb/tb_tank_motion_ctrl.sv
// Randomized bench for tank_motion_ctrl: drives commands, map acks and bullet-engine
// backpressure, and compares every output each cycle with a behavioural tank model.
module tb_tank_motion_ctrl;

    localparam int GRID_W        = 26;
    localparam int GRID_H        = 26;
    localparam int START_X       = 8;
    localparam int START_Y       = 24;
    localparam int START_DIR     = 2;
    localparam int STEP_DIV      = 4;
    localparam int FIRE_COOLDOWN = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [4:0] cmd;
    logic       map_req;
    logic [4:0] map_x;
    logic [4:0] map_y;
    logic       map_ack;
    logic       map_blocked;
    logic [4:0] pos_x;
    logic [4:0] pos_y;
    logic [1:0] dir;
    logic       moving;
    logic       fire_valid;
    logic       fire_ready;
    logic [4:0] fire_x;
    logic [4:0] fire_y;
    logic [1:0] fire_dir;

    always #5 clk = ~clk;

    tank_motion_ctrl #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .START_X(START_X), .START_Y(START_Y),
        .START_DIR(START_DIR), .STEP_DIV(STEP_DIV), .FIRE_COOLDOWN(FIRE_COOLDOWN)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .cmd(cmd),
        .map_req(map_req), .map_x(map_x), .map_y(map_y),
        .map_ack(map_ack), .map_blocked(map_blocked),
        .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .moving(moving),
        .fire_valid(fire_valid), .fire_ready(fire_ready),
        .fire_x(fire_x), .fire_y(fire_y), .fire_dir(fire_dir)
    );

    int errors = 0;
    int checks = 0;

    // Tank model: position as integers, step attempts as a tick tally, and the
    // lookup in flight tracked as "waiting for the map" then "about to move".
    int dx [4] = '{0, 1, 0, -1};
    int dy [4] = '{1, 0, -1, 0};
    int m_x, m_y, m_dir, m_ticks_same;
    bit m_waiting_map, m_move_pending, m_moving;
    int m_tx, m_ty;
    int m_cool;
    bit m_fv;
    int m_fx, m_fy, m_fd;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep(input bit rst, input bit tk, input logic [4:0] c,
                             input bit ack, input bit blk, input bit rdy);
        int nbits;
        int want;
        if (rst) begin
            m_x = START_X; m_y = START_Y; m_dir = START_DIR; m_ticks_same = 0;
            m_waiting_map = 0; m_move_pending = 0; m_moving = 0;
            m_cool = 0; m_fv = 0;
            return;
        end
        // Fire path sees the position and heading from before this cycle's update.
        if (m_fv && rdy) begin
            m_fv = 0;
            m_cool = FIRE_COOLDOWN;
        end else if (tk) begin
            if (m_cool > 0) m_cool = m_cool - 1;
            else if (c[4] && !m_fv) begin
                m_fv = 1; m_fx = m_x; m_fy = m_y; m_fd = m_dir;
            end
        end
        m_moving = 0;
        if (m_move_pending) begin
            m_x = m_tx; m_y = m_ty;
            m_moving = 1;
            m_move_pending = 0;
        end else if (m_waiting_map) begin
            if (ack) begin
                m_waiting_map = 0;
                m_move_pending = !blk;
            end
        end else if (tk) begin
            nbits = $countones(c[3:0]);
            want = 0;
            for (int i = 0; i < 4; i++) if (c[i]) want = i;
            if (nbits != 1) begin
                m_ticks_same = 0;
            end else if (want != m_dir) begin
                m_dir = want;
                m_ticks_same = 0;
            end else begin
                m_ticks_same = m_ticks_same + 1;
                if (m_ticks_same == STEP_DIV) begin
                    m_ticks_same = 0;
                    m_tx = m_x + dx[m_dir];
                    m_ty = m_y + dy[m_dir];
                    if (m_tx >= 0 && m_tx < GRID_W && m_ty >= 0 && m_ty < GRID_H)
                        m_waiting_map = 1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit tk, input logic [4:0] c,
                                 input bit ack, input bit blk, input bit rdy);
        @(negedge clk);
        reset = rst; tick = tk; cmd = c;
        map_ack = ack; map_blocked = blk; fire_ready = rdy;
        modelStep(rst, tk, c, ack, blk, rdy);
        @(posedge clk);
        #1;
        checkOutput("pos_x", 32'(pos_x), 32'(m_x));
        checkOutput("pos_y", 32'(pos_y), 32'(m_y));
        checkOutput("dir", 32'(dir), 32'(m_dir));
        checkOutput("moving", 32'(moving), 32'(m_moving));
        checkOutput("map_req", 32'(map_req), 32'(m_waiting_map));
        if (m_waiting_map) begin
            checkOutput("map_x", 32'(map_x), 32'(m_tx));
            checkOutput("map_y", 32'(map_y), 32'(m_ty));
        end
        checkOutput("fire_valid", 32'(fire_valid), 32'(m_fv));
        if (m_fv) begin
            checkOutput("fire_x", 32'(fire_x), 32'(m_fx));
            checkOutput("fire_y", 32'(fire_y), 32'(m_fy));
            checkOutput("fire_dir", 32'(fire_dir), 32'(m_fd));
        end
    endtask

    initial begin
        int seg_dir;
        int seg_len;
        bit tk, ack, blk, rdy, rst;
        logic [4:0] c;

        reset = 1'b1; tick = 1'b0; cmd = 5'd0;
        map_ack = 1'b0; map_blocked = 1'b0; fire_ready = 1'b0;

        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 5'b10100, 1'b1, 1'b0, 1'b1);

        // Early segments head up then hard left so the x=0 edge is reached.
        for (int seg = 0; seg < 60; seg++) begin
            if (seg == 0)      seg_dir = 2;
            else if (seg == 1) seg_dir = 3;
            else               seg_dir = $urandom_range(0, 3);
            seg_len = (seg == 1) ? 260 : $urandom_range(60, 200);
            for (int n = 0; n < seg_len; n++) begin
                tk = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 99) < 85) c[3:0] = 4'b0001 << seg_dir;
                else                            c[3:0] = 4'($urandom_range(0, 15));
                c[4] = ($urandom_range(0, 3) == 0);
                if (m_waiting_map) ack = ($urandom_range(0, 2) == 0);
                else               ack = ($urandom_range(0, 19) == 0);
                blk = ($urandom_range(0, 3) == 0);
                rdy = ($urandom_range(0, 2) == 0);
                rst = (m_waiting_map && $urandom_range(0, 39) == 0) ||
                      ($urandom_range(0, 999) == 0);
                applyStimulus(rst, tk, c, ack, blk, rdy);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
